adder_chunk_seq: RTL and testbench
==================================

Name: adder_chunk_seq

Overview:
- Multi-cycle sequencer that adds WIDTH-bit operands using one external CHUNK-bit `adder` instance, one slice per cycle, least-significant slice first.
- Propagates the carry between slices in a register.
- Accepts operations and returns results over valid/ready handshakes.
- Sits between a requester and a narrow `adder` so wide adds run without a wide carry chain.

Parameters:
- WIDTH, 64, operand/result width; must be an integer multiple of CHUNK (else elaboration error).
- CHUNK, 16, width of the external adder slice; 1..WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  sequencer can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to slice 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of top slice
- busy  output  1  high in RUN
- add_a  output  CHUNK  slice of A to external adder
- add_b  output  CHUNK  slice of B to external adder
- add_cin  output  1  carry into external adder
- add_sum  input  CHUNK  external adder sum (combinational)
- add_cout  input  1  external adder carry-out

Behaviour:
- NCH = WIDTH/CHUNK; slice index idx has width clog2(NCH), minimum 1.
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0): state=IDLE, idx=0, carry reg=0, operand regs=0, sum=0, cout=0, out_valid=0, busy=0. Reset mid-RUN or in DONE aborts the operation; no result is emitted.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN).
- IDLE: on in_valid&&in_ready, latch a, b, cin into registers; set idx=0; go to RUN. a/b/cin are ignored at any other time.
- RUN, each cycle:
  - add_a = a_reg[idx*CHUNK +: CHUNK], add_b = b_reg[idx*CHUNK +: CHUNK], add_cin = carry reg (the latched cin when idx=0).
  - At the clock edge: sum[idx*CHUNK +: CHUNK] <= add_sum, carry <= add_cout, idx <= idx+1.
  - When idx==NCH-1: cout <= add_cout, idx <= 0, go to DONE.
- Outside RUN, add_a/add_b/add_cin are driven to 0.
- Latency: out_valid rises exactly NCH cycles after the accepting edge. For NCH=1 (CHUNK=WIDTH), out_valid rises 1 cycle after accept.
- DONE: sum/cout held stable while out_valid=1 and out_ready=0 (any number of cycles). On out_ready=1, go to IDLE next edge; sum/cout keep their values until overwritten.
- Result width rule: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of a+b+cin.
- in_valid asserted in RUN/DONE: not accepted; requester must hold it until in_ready.
- Throughput without the optional feature: one operation per NCH+2 cycles.

Optional Feature:
- Macro: ADDSEQ_PIPE_ACCEPT_EN.
- Defined:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept in DONE with out_ready=1 latches the new operands and goes directly to RUN; sum/cout of the previous result are valid in that cycle and are overwritten slice by slice afterwards.
  - Throughput: one operation per NCH+1 cycles.
- Undefined: in_ready only in IDLE, as specified above.

Test Plan:
- WIDTH=64, CHUNK=16, a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept, sum=0, cout=1.
- a=0000_0000_0000_FFFF, b=1, cin=0 -> sum=0000_0000_0001_0000, cout=0; carry crosses slice boundary 0->1.
- a=0, b=0, cin=1 -> sum=1, cout=0; add_cin=1 only in first RUN cycle.
- out_ready held 0 for 5 cycles after out_valid -> sum/cout unchanged, in_ready=0, second in_valid not accepted; accepted 1 cycle after out_ready=1 handshake.
- rst_n pulsed low during RUN (idx=2) -> immediately IDLE, out_valid=0, sum=0, in_ready=1; next op a=5, b=7 -> sum=12.
- CHUNK=64, WIDTH=64, a=8000_0000_0000_0000, b=8000_0000_0000_0000 -> out_valid 1 cycle after accept, sum=0, cout=1; with ADDSEQ_PIPE_ACCEPT_EN, back-to-back ops complete every 2 cycles.

Source files
------------

// File: rtl/adder_chunk_seq.sv
// adder_chunk_seq: multi-cycle wide adder built on one external CHUNK-bit adder.
// Operands are latched on accept, fed to the external adder one slice per cycle
// (least-significant first) with the inter-slice carry held in a register, and
// the registered result is returned over a valid/ready handshake.
//
// Optional build macro ADDSEQ_PIPE_ACCEPT_EN: when defined, a new operation may
// be accepted in the same cycle the previous result is consumed, skipping IDLE.
module adder_chunk_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Request side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  // Result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  // External slice adder
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_sum,
  input  logic             add_cout
);

  localparam int unsigned NCH  = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

  // Reject parameter sets that cannot be sliced evenly.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_chunk_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic              accept;
  logic              last_slice;
  logic [31:0]       base;

  // Bit offset of the slice currently being processed.
  assign base       = 32'(idx_q) * CHUNK;
  assign last_slice = (idx_q == IdxW'(NCH - 1));

  // Handshake and status outputs.
  always_comb begin
`ifdef ADDSEQ_PIPE_ACCEPT_EN
    in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
`else
    in_ready = (state_q == StIdle);
`endif
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun);
    accept    = in_valid && in_ready;
  end

  // Slice feed to the external adder; quiet (all zero) outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_a   = a_q[base +: CHUNK];
      add_b   = b_q[base +: CHUNK];
      add_cin = carry_q;
    end
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        sum_d[base +: CHUNK] = add_sum;
        carry_d              = add_cout;
        if (last_slice) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDone: begin
        // Result stays frozen until the consumer takes it.
        if (out_ready) begin
          if (accept) begin
            // Only reachable with pipelined accept; old result is overwritten
            // slice by slice from the next cycle on.
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_adder_chunk_seq.sv
// tb_adder_chunk_seq: directed bench for adder_chunk_seq with a 64/16 instance
// and a 64/64 instance, each driving its own behavioural slice adder.
module tb_adder_chunk_seq;

`ifdef ADDSEQ_PIPE_ACCEPT_EN
  localparam bit Pipe = 1'b1;
`else
  localparam bit Pipe = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_valid_w;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_ready;

  logic        in_ready, out_valid, cout, busy, add_cin, add_cout;
  logic [63:0] sum;
  logic [15:0] add_a, add_b, add_sum;

  logic        w_in_ready, w_out_valid, w_cout, w_busy, w_add_cin, w_add_cout;
  logic [63:0] w_sum, w_add_a, w_add_b, w_add_sum;

  int total;
  int bad;

  adder_chunk_seq #(
    .WIDTH(64),
    .CHUNK(16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  adder_chunk_seq #(
    .WIDTH(64),
    .CHUNK(64)
  ) u_dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid_w),
    .in_ready (w_in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(w_out_valid),
    .out_ready(out_ready),
    .sum      (w_sum),
    .cout     (w_cout),
    .busy     (w_busy),
    .add_a    (w_add_a),
    .add_b    (w_add_b),
    .add_cin  (w_add_cin),
    .add_sum  (w_add_sum),
    .add_cout (w_add_cout)
  );

  // External slice adders.
  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  assign {w_add_cout, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + 65'(w_add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_w = 1'b0;
    a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #3;
    total++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b want=1000", {in_ready, out_valid, busy, cout});
    end
    total++;
    if (sum !== 64'h0 || add_a !== 16'h0 || add_cin !== 1'b0) begin
      bad++; $display("FAIL reset_data sum=%h add_a=%h add_cin=%b want 0", sum, add_a, add_cin);
    end
    total++;
    if ({w_in_ready, w_out_valid, w_busy} !== 3'b100) begin
      bad++; $display("FAIL reset_wide got=%b want=100", {w_in_ready, w_out_valid, w_busy});
    end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_carry_all();
    int n;
    @(posedge clk); #1;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || add_a !== 16'hFFFF || add_b !== 16'h1 || add_cin !== 1'b0) begin
      bad++; $display("FAIL carry_all_first busy=%b add_a=%h add_b=%h add_cin=%b want 1/ffff/0001/0",
                      busy, add_a, add_b, add_cin);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (out_valid) break;
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL carry_all_latency got=%0d want=4", n); end
    total++;
    if (sum !== 64'h0 || cout !== 1'b1) begin
      bad++; $display("FAIL carry_all_result sum=%h cout=%b want 0/1", sum, cout);
    end
  endtask

  task automatic test_slice_cross();
    int n;
    @(posedge clk); #1;
    a = 64'h0000_0000_0000_FFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (add_a !== 16'hFFFF || add_b !== 16'h1 || add_cin !== 1'b0) begin
      bad++; $display("FAIL cross_slice0 add_a=%h add_b=%h add_cin=%b", add_a, add_b, add_cin);
    end
    @(posedge clk); #1;
    total++;
    if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b1) begin
      bad++; $display("FAIL cross_slice1 add_a=%h add_b=%h add_cin=%b want 0/0/1",
                      add_a, add_b, add_cin);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (out_valid) break;
    end
    total++;
    if (n !== 4 || sum !== 64'h0000_0000_0001_0000 || cout !== 1'b0) begin
      bad++; $display("FAIL cross_result lat=%0d sum=%h cout=%b want 4/10000/0", n, sum, cout);
    end
  endtask

  task automatic test_cin();
    @(posedge clk); #1;
    a = 64'h0; b = 64'h0; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== 1'b1 || add_cin !== (i == 0)) begin
        bad++; $display("FAIL cin_cycle%0d busy=%b add_cin=%b want 1/%0d", i, busy, add_cin, i == 0);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b1 || sum !== 64'h1 || cout !== 1'b0) begin
      bad++; $display("FAIL cin_result ov=%b sum=%h cout=%b want 1/1/0", out_valid, sum, cout);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    @(posedge clk); #1;
    a = 64'd1; b = 64'd2; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_timeout out_valid=%b want 1", out_valid); end
    a = 64'd10; b = 64'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, busy} !== 3'b100 || sum !== 64'd3 || cout !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d ov/ir/busy=%b sum=%h cout=%b want 100/3/0",
                        i, {out_valid, in_ready, busy}, sum, cout);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== Pipe) begin
      bad++; $display("FAIL bp_ready_in_done got=%b want=%b", in_ready, Pipe);
    end
    @(posedge clk); #1;
    if (!Pipe) begin
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
        bad++; $display("FAIL bp_idle ir/ov/busy=%b want 100", {in_ready, out_valid, busy});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept busy=%b want 1", busy); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || sum !== 64'd30 || cout !== 1'b0) begin
      bad++; $display("FAIL bp_second_result seen=%b sum=%h cout=%b want 1/1e/0", seen, sum, cout);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(posedge clk); #1;
    a = 64'd1; b = 64'd2; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || sum !== 64'd3) begin
      bad++; $display("FAIL midrun_partial busy=%b sum=%h want 1/3", busy, sum);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== 64'h0) begin
      bad++; $display("FAIL midrun_abort ir/ov/busy/cout=%b sum=%h want 1000/0",
                      {in_ready, out_valid, busy, cout}, sum);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_no_result ov=%b want 0", out_valid); end
    a = 64'd5; b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || sum !== 64'd12 || cout !== 1'b0) begin
      bad++; $display("FAIL midrun_next seen=%b sum=%h cout=%b want 1/c/0", seen, sum, cout);
    end
  endtask

  task automatic test_wide();
    @(posedge clk); #1;
    a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; cin = 1'b0;
    in_valid_w = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    total++;
    if (w_busy !== 1'b1 || w_out_valid !== 1'b0 || w_add_a !== 64'h8000_0000_0000_0000) begin
      bad++; $display("FAIL wide_run busy=%b ov=%b add_a=%h", w_busy, w_out_valid, w_add_a);
    end
    @(posedge clk); #1;
    total++;
    if (w_out_valid !== 1'b1 || w_sum !== 64'h0 || w_cout !== 1'b1) begin
      bad++; $display("FAIL wide_result ov=%b sum=%h cout=%b want 1/0/1", w_out_valid, w_sum, w_cout);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    // Narrow instance: in_valid held, result gap is NCH+2 (NCH+1 pipelined).
    @(posedge clk); #1;
    a = 64'd1; b = 64'd1; cin = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (t0 < 0) t0 = c;
        else begin t1 = c; break; end
      end
    end
    in_valid = 1'b0;
    total++;
    if (t1 < 0 || (t1 - t0) !== (Pipe ? 5 : 6) || sum !== 64'd2) begin
      bad++; $display("FAIL b2b_narrow gap=%0d sum=%h want %0d/2", t1 - t0, sum, Pipe ? 5 : 6);
    end
    repeat (2) @(posedge clk);
    #1;
    in_valid_w = 1'b1;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (w_out_valid) begin
        if (t0 < 0) t0 = c;
        else begin t1 = c; break; end
      end
    end
    in_valid_w = 1'b0;
    total++;
    if (t1 < 0 || (t1 - t0) !== (Pipe ? 2 : 3) || w_sum !== 64'd2) begin
      bad++; $display("FAIL b2b_wide gap=%0d sum=%h want %0d/2", t1 - t0, w_sum, Pipe ? 2 : 3);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_carry_all();
    test_slice_cross();
    test_cin();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
